// File: rtl/mul_share_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_share_pkg
// Purpose  : Shared types and defaults for the shared-multiplier arbiter.
//            Holds the FSM state encoding, the default operand/product
//            widths and the requester-ID width helper.
// Options  : MUL_SHARE_FIXED_PRIO_EN (used by rr_pick / mul_share_arbiter)
// Revision : 1.0  initial release
// ============================================================================
package mul_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int C_DEF_N_A      = 8;
  localparam int C_DEF_N_B      = 8;
  localparam int C_DEF_N_OUTPUT = C_DEF_N_A + C_DEF_N_B;

  // Requester index width; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_share_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational request picker for the shared multiplier.
//            Default build: round-robin search starting at i_ptr, wrapping
//            at N_REQ. With MUL_SHARE_FIXED_PRIO_EN defined it becomes a
//            lowest-index priority encoder and has no pointer input.
// Ports    : i_req     - request vector
//            i_ptr     - highest-priority index (round-robin build only)
//            o_onehot  - one-hot winner (zero when no request)
//            o_idx     - encoded winner index (zero when no request)
// Options  : MUL_SHARE_FIXED_PRIO_EN
// Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
`ifndef MUL_SHARE_FIXED_PRIO_EN
  input  logic [ID_W-1:0]  i_ptr,
`endif
  output logic [N_REQ-1:0] o_onehot,
  output logic [ID_W-1:0]  o_idx
);

  logic w_found;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
`ifndef MUL_SHARE_FIXED_PRIO_EN
    // First pass covers indices ptr..N_REQ-1; the second pass below then
    // covers the wrapped part 0..ptr-1 (it revisits the upper part only if
    // nothing there was asserted, which cannot then match).
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && i_req[i] && (i >= int'(i_ptr))) begin
        w_found     = 1'b1;
        o_onehot[i] = 1'b1;
        o_idx       = ID_W'(i);
      end
    end
`endif
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && i_req[i]) begin
        w_found     = 1'b1;
        o_onehot[i] = 1'b1;
        o_idx       = ID_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mul_share_arbiter
// Purpose  : Shares one combinational n_A x n_B multiplier among N_REQ
//            requesters. Picks a winner, registers its operands into the
//            datapath inputs, captures the product a cycle later and returns
//            it with the requester ID on a valid/ready response channel.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            req, A_in, B_in     - requests and flattened operands
//            gnt                 - one-cycle one-hot accept (combinational)
//            dp_in1, dp_in2      - registered operands to the multiplier
//            dp_out              - multiplier product
//            rsp_valid/id/data   - response channel, rsp_ready from consumer
//            busy                - FSM not idle
// Options  : MUL_SHARE_FIXED_PRIO_EN - lowest index always wins, no pointer
// Revision : 1.0  initial release
// ============================================================================
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int n_A      = C_DEF_N_A,
  parameter int n_B      = C_DEF_N_B,
  parameter int n_OUTPUT = C_DEF_N_OUTPUT,
  parameter int ID_W     = id_width(N_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*n_A-1:0]  A_in,
  input  logic [N_REQ*n_B-1:0]  B_in,
  output logic [N_REQ-1:0]      gnt,
  output logic [n_A-1:0]        dp_in1,
  output logic [n_B-1:0]        dp_in2,
  input  logic [n_OUTPUT-1:0]   dp_out,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [n_OUTPUT-1:0]   rsp_data,
  input  logic                  rsp_ready,
  output logic                  busy
);

  state_t                r_state;
  logic [ID_W-1:0]       r_win_id;
  logic [n_A-1:0]        r_dp_in1;
  logic [n_B-1:0]        r_dp_in2;
  logic                  r_rsp_valid;
  logic [ID_W-1:0]       r_rsp_id;
  logic [n_OUTPUT-1:0]   r_rsp_data;

  logic [N_REQ-1:0]      w_onehot;
  logic [ID_W-1:0]       w_idx;
  logic [n_A-1:0]        w_a_sel;
  logic [n_B-1:0]        w_b_sel;

`ifndef MUL_SHARE_FIXED_PRIO_EN
  localparam logic [ID_W-1:0] c_last = ID_W'(N_REQ - 1);
  logic [ID_W-1:0]       r_rr_ptr;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .i_req    (req),
`ifndef MUL_SHARE_FIXED_PRIO_EN
    .i_ptr    (r_rr_ptr),
`endif
    .o_onehot (w_onehot),
    .o_idx    (w_idx)
  );

  // Winner's operands out of the flattened buses.
  always_comb begin
    w_a_sel = '0;
    w_b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_idx == ID_W'(i)) begin
        w_a_sel = A_in[i*n_A +: n_A];
        w_b_sel = B_in[i*n_B +: n_B];
      end
    end
  end

  // Grants only exist in IDLE; reset masks them in the same cycle.
  assign gnt = ((r_state == IDLE) && !reset) ? w_onehot : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_win_id    <= '0;
      r_dp_in1    <= '0;
      r_dp_in2    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
`ifndef MUL_SHARE_FIXED_PRIO_EN
      r_rr_ptr    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_dp_in1 <= w_a_sel;
            r_dp_in2 <= w_b_sel;
            r_win_id <= w_idx;
`ifndef MUL_SHARE_FIXED_PRIO_EN
            r_rr_ptr <= (w_idx == c_last) ? '0 : w_idx + 1'b1;
`endif
            r_state  <= EXEC;
          end
        end
        EXEC: begin
          // Multiplier output has settled from the operands registered
          // last cycle; capture it untouched.
          r_rsp_data  <= dp_out;
          r_rsp_id    <= r_win_id;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign dp_in1    = r_dp_in1;
  assign dp_in2    = r_dp_in2;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_share_arbiter
// Purpose  : Self-checking bench for mul_share_arbiter with a behavioural
//            multiplier on the datapath and a response scoreboard.
// Options  : MUL_SHARE_FIXED_PRIO_EN changes the expected grant order
// Revision : 1.0  initial release
// ============================================================================
module tb_mul_share_arbiter;

  localparam int N   = 4;
  localparam int NA  = 8;
  localparam int NB  = 8;
  localparam int NO  = 16;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [NA-1:0]     a_arr [N];
  logic [NB-1:0]     b_arr [N];
  logic [N*NA-1:0]   A_in;
  logic [N*NB-1:0]   B_in;
  logic [N-1:0]      gnt;
  logic [NA-1:0]     dp_in1;
  logic [NB-1:0]     dp_in2;
  logic [NO-1:0]     dp_out;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [NO-1:0]     rsp_data;
  logic              rsp_ready;
  logic              busy;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [NO-1:0]  data;
  } exp_t;

  exp_t sb [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  assign A_in   = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
  assign B_in   = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};
  // Multiplier datapath shared by the requesters.
  assign dp_out = NO'(dp_in1) * NO'(dp_in2);

  mul_share_arbiter #(
    .N_REQ    (N),
    .n_A      (NA),
    .n_B      (NB),
    .n_OUTPUT (NO),
    .ID_W     (IDW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .A_in      (A_in),
    .B_in      (B_in),
    .gnt       (gnt),
    .dp_in1    (dp_in1),
    .dp_in2    (dp_in2),
    .dp_out    (dp_out),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    n_tests++;
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs_v, exp_v);
    end
  endtask

  // Move to the drive point just after the next rising edge.
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  // Sample at the falling edge: check gnt, record expected responses for
  // grants and retire responses on each valid/ready handshake.
  task automatic obs(input string tag, input logic [N-1:0] exp_gnt, input bit push);
    exp_t e;
    @(negedge clk);
    chk({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    if (push && (exp_gnt != '0)) begin
      for (int i = 0; i < N; i++) begin
        if (exp_gnt[i]) begin
          e.id   = IDW'(i);
          e.data = NO'(a_arr[i]) * NO'(b_arr[i]);
          sb.push_back(e);
        end
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk({tag, "_rsp_unexpected"}, 32'(rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk({tag, "_rsp_id"},   32'(rsp_id),   32'(e.id));
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(e.data));
      end
    end
  endtask

  logic [N-1:0] fair_order [6];

  initial begin
    reset     = 1'b1;
    req       = 4'b1111;
    rsp_ready = 1'b1;
    a_arr[0] = 8'h0F; b_arr[0] = 8'h11;
    a_arr[1] = 8'h12; b_arr[1] = 8'h34;
    a_arr[2] = 8'h03; b_arr[2] = 8'h05;
    a_arr[3] = 8'hA5; b_arr[3] = 8'h5A;
`ifdef MUL_SHARE_FIXED_PRIO_EN
    for (int i = 0; i < 6; i++) fair_order[i] = 4'b0001;
`else
    fair_order[0] = 4'b0001; fair_order[1] = 4'b0010;
    fair_order[2] = 4'b0100; fair_order[3] = 4'b1000;
    fair_order[4] = 4'b0001; fair_order[5] = 4'b0010;
`endif

    // 1: reset held with all requests asserted
    edge_step();
    for (int c = 0; c < 3; c++) begin
      obs("rst", 4'b0000, 1'b0);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_data",  32'(rsp_data),  32'd0);
      chk("rst_dp1",   32'(dp_in1),    32'd0);
      chk("rst_dp2",   32'(dp_in2),    32'd0);
      chk("rst_busy",  32'(busy),      32'd0);
      edge_step();
    end
    reset = 1'b0;
    req   = 4'b0000;

    // 2: single request from requester 0
    req = 4'b0001;
    obs("single_t0", 4'b0001, 1'b1);
    chk("single_busy_t0", 32'(busy), 32'd0);
    edge_step();
    req = 4'b0000;
    obs("single_t1", 4'b0000, 1'b1);
    chk("single_busy_t1", 32'(busy), 32'd1);
    chk("single_valid_t1", 32'(rsp_valid), 32'd0);
    edge_step();
    obs("single_t2", 4'b0000, 1'b1);
    chk("single_valid_t2", 32'(rsp_valid), 32'd1);
    chk("single_data_t2", 32'(rsp_data), 32'h00FF);
    edge_step();
    obs("single_t3", 4'b0000, 1'b1);
    chk("single_busy_t3", 32'(busy), 32'd0);
    chk("single_valid_t3", 32'(rsp_valid), 32'd0);

    // Restart with the pointer at 0 for the fairness run.
    edge_step();
    reset = 1'b1;
    edge_step();
    reset = 1'b0;

    // 3: all four requesting continuously
    req = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      obs("fair_grant", fair_order[g], 1'b1);
      edge_step();
      obs("fair_exec", 4'b0000, 1'b1);
      edge_step();
      obs("fair_resp", 4'b0000, 1'b1);
      edge_step();
    end
    req = 4'b0000;
    obs("fair_idle", 4'b0000, 1'b1);
    edge_step();

    // 4: backpressure on requester 1's response
    a_arr[1] = 8'hFF; b_arr[1] = 8'hFF;
    req = 4'b0010;
    rsp_ready = 1'b0;
    obs("bp_grant", 4'b0010, 1'b1);
    edge_step();
    req = 4'b0100;
    obs("bp_exec", 4'b0000, 1'b1);
    edge_step();
    for (int c = 0; c < 5; c++) begin
      obs("bp_stall", 4'b0000, 1'b1);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data",  32'(rsp_data),  32'hFE01);
      chk("bp_id",    32'(rsp_id),    32'd1);
      chk("bp_dp1",   32'(dp_in1),    32'hFF);
      edge_step();
    end
    rsp_ready = 1'b1;
    obs("bp_release", 4'b0000, 1'b1);
    edge_step();
    obs("bp_next", 4'b0100, 1'b1);
    edge_step();
    req = 4'b0000;
    obs("bp_next_exec", 4'b0000, 1'b1);
    edge_step();
    obs("bp_next_resp", 4'b0000, 1'b1);
    edge_step();

    // 5: reset during EXEC discards requester 3's operation
    req = 4'b1000;
    obs("rexec_grant", 4'b1000, 1'b0);
    edge_step();
    req   = 4'b0000;
    reset = 1'b1;
    obs("rexec_in_exec", 4'b0000, 1'b0);
    edge_step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      obs("rexec_after", 4'b0000, 1'b0);
      chk("rexec_valid", 32'(rsp_valid), 32'd0);
      chk("rexec_busy",  32'(busy),      32'd0);
      edge_step();
    end
    req = 4'b1001;
    obs("rexec_ptr", 4'b0001, 1'b1);
    edge_step();
    req = 4'b0000;
    obs("rexec_exec", 4'b0000, 1'b1);
    edge_step();
    obs("rexec_resp", 4'b0000, 1'b1);
    edge_step();

    // 6: boundary operands on requester 2
    a_arr[2] = 8'h00; b_arr[2] = 8'hFF;
    req = 4'b0100;
    obs("bnd0_grant", 4'b0100, 1'b1);
    edge_step();
    req = 4'b0000;
    obs("bnd0_exec", 4'b0000, 1'b1);
    edge_step();
    obs("bnd0_resp", 4'b0000, 1'b1);
    chk("bnd0_data", 32'(rsp_data), 32'h0000);
    chk("bnd0_id",   32'(rsp_id),   32'd2);
    edge_step();
    a_arr[2] = 8'h80; b_arr[2] = 8'h02;
    req = 4'b0100;
    obs("bnd1_grant", 4'b0100, 1'b1);
    edge_step();
    req = 4'b0000;
    obs("bnd1_exec", 4'b0000, 1'b1);
    edge_step();
    obs("bnd1_resp", 4'b0000, 1'b1);
    chk("bnd1_data", 32'(rsp_data), 32'h0100);
    chk("bnd1_id",   32'(rsp_id),   32'd2);
    edge_step();

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
Shares one combinational multiplier datapath (INPUT1/INPUT2 -> OUTPUT, n_A x n_B -> n_OUTPUT) among N_REQ requesters.
- Arbitrates round-robin.
- Latches the winner's operands into the datapath input registers.
- Captures the product one cycle later.
- Returns the product with the requester ID over a valid/ready response channel.

Sits between the requesting blocks and the multiplier instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
n_A, 8, operand A width
n_B, 8, operand B width
n_OUTPUT, 16, product width (n_A+n_B)
ID_W, 2, requester ID width (clog2(N_REQ), min 1)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
req  input  N_REQ  per-requester request; held with operands until granted
A_in  input  N_REQ*n_A  flattened operand A; requester i at [i*n_A +: n_A]
B_in  input  N_REQ*n_B  flattened operand B; requester i at [i*n_B +: n_B]
gnt  output  N_REQ  one-hot accept pulse, one cycle
dp_in1  output  n_A  registered operand to datapath INPUT1
dp_in2  output  n_B  registered operand to datapath INPUT2
dp_out  input  n_OUTPUT  datapath OUTPUT (combinational product of dp_in1, dp_in2)
rsp_valid  output  1  response valid
rsp_id  output  ID_W  index of the requester owning rsp_data
rsp_data  output  n_OUTPUT  captured product
rsp_ready  input  1  response consumer ready
busy  output  1  high when state != IDLE

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it overrides every other input in that cycle.
- Reset values: state=IDLE, rr_ptr=0, dp_in1=0, dp_in2=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0. gnt is forced to 0 while reset=1.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If |req: gnt = one-hot of the winner (combinational, same cycle). dp_in1/dp_in2 <= winner's A/B. win_id <= winner. rr_ptr <= winner+1 (mod N_REQ). Next state EXEC.
  - If no req: gnt=0, all registers hold.
- EXEC: rsp_data <= dp_out, rsp_id <= win_id, rsp_valid <= 1. Next state RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are held stable.
  - When rsp_ready=1: rsp_valid <= 0, next state IDLE.
  - When rsp_ready=0: stay in RESP indefinitely. No grants are issued and dp_in1/dp_in2 hold.
- Latency: request accepted in cycle t -> rsp_valid first high in cycle t+2. Minimum issue interval is 3 cycles with rsp_ready tied high.
- Round-robin arbitration: search order is rr_ptr, rr_ptr+1, ... wrapping at N_REQ. The first asserted req wins. After reset, requester 0 has highest priority. rr_ptr wraps from N_REQ-1 to 0.
- Requester contract: a requester deasserts req, or presents its next operands, the cycle after it sees its gnt bit. req changes while in EXEC or RESP are ignored.
- Arithmetic: the block performs no arithmetic on data. dp_out is captured unmodified, full n_OUTPUT width.
- Reset mid-operation (EXEC or RESP): the in-flight result is discarded, rsp_valid=0 the next cycle, and rr_ptr returns to 0.
- rsp_ready=1 outside RESP: ignored.

Optional Feature:
Macro: MUL_SHARE_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest asserted index always wins. rr_ptr is removed, and a continuously asserted req[0] starves all other requesters.
- Undefined (default): round-robin as specified above.
- All other behaviour and timing are identical in both builds.

Decomposition:
- Package mul_share_pkg holds:
  - state encoding constants IDLE=2'd0, EXEC=2'd1, RESP=2'd2;
  - default widths (n_A=8, n_B=8, n_OUTPUT=16);
  - a clog2-based ID width function.
- One sub-module, rr_pick: combinational. Inputs: req vector and rr_ptr. Outputs: one-hot winner and encoded index. Under MUL_SHARE_FIXED_PRIO_EN it reduces to a lowest-index priority encoder.
- FSM, operand registers and response registers live in mul_share_arbiter.
- The bench connects dp_in1/dp_in2/dp_out to the team's multiplier datapath.

Test Plan:
1. Reset held 3 cycles with all req=1 -> gnt=0, rsp_valid=0, rsp_data=16'h0000, dp_in1=0, dp_in2=0, busy=0 throughout.
2. Single request: req=4'b0001, A0=8'h0F, B0=8'h11, rsp_ready=1 -> gnt=4'b0001 in cycle t; rsp_valid=1, rsp_id=0, rsp_data=16'h00FF at t+2; busy low again at t+3.
3. Fairness: req=4'b1111 held continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1, one grant every 3 cycles. With MUL_SHARE_FIXED_PRIO_EN defined -> always 0.
4. Backpressure: req1 with A=8'hFF, B=8'hFF, rsp_ready=0 for 5 cycles -> rsp_data=16'hFE01, rsp_id=1, both stable; no gnt while req2 is asserted. rsp_ready=1 -> IDLE next cycle, then gnt=4'b0100.
5. Reset in EXEC: reset pulsed the cycle after gnt for req3 -> rsp_valid never rises for that operation. Next request with req=4'b1001 grants requester 0 (pointer reset).
6. Boundary operands: req2 with A=8'h00, B=8'hFF -> 16'h0000; then req2 with A=8'h80, B=8'h02 -> 16'h0100, rsp_id=2 for both.
